// File: rtl/sys_pkg.sv
// Shared constants for the run controller: FSM state codes, LED source selects
// and the positions of the status bits in the LED word.
package sys_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [1:0] SEL_PC    = 2'd0;
  localparam logic [1:0] SEL_INSTR = 2'd1;
  localparam logic [1:0] SEL_REG   = 2'd2;
  localparam logic [1:0] SEL_STAT  = 2'd3;

  localparam int unsigned LED_RUN    = 26;
  localparam int unsigned LED_HALT   = 25;
  localparam int unsigned LED_FLAG   = 24;
  localparam int unsigned LED_DATA_W = 24;
  localparam int unsigned STAT_CYC_W = 16;

endpackage

// File: rtl/sys_led_mux.sv
// Registered LED display: run/halt/flag status bits plus a selectable
// 24-bit debug field.
module sys_led_mux
  import sys_pkg::*;
#(
  parameter int unsigned LED_W = 27,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic [1:0]       state,
  input  logic             exc,
  input  logic             tmo,
  input  logic [CYC_W-1:0] cycle,
  input  logic [31:0]      dbg_pc,
  input  logic [31:0]      dbg_instr,
  input  logic [31:0]      dbg_reg_data,
  output logic [LED_W-1:0] leds
);

  logic [LED_W-1:0]      leds_d;
  logic [LED_DATA_W-1:0] data;
  logic                  unused_dbg;

  // Only the low 24 bits of each debug word fit on the display.
  assign unused_dbg = ^{dbg_pc[31:24], dbg_instr[31:24], dbg_reg_data[31:24]};

  always_comb begin
    data = '0;
    case (sel)
      SEL_PC:    data = dbg_pc[LED_DATA_W-1:0];
      SEL_INSTR: data = dbg_instr[LED_DATA_W-1:0];
      SEL_REG:   data = dbg_reg_data[LED_DATA_W-1:0];
      SEL_STAT:  data = {tmo, exc, state, 4'b0000, STAT_CYC_W'(cycle)};
      default:   data = '0;
    endcase
  end

  always_comb begin
    leds_d                   = '0;
    leds_d[LED_RUN]          = (state == ST_RUN);
    leds_d[LED_HALT]         = (state == ST_HALT);
    leds_d[LED_FLAG]         = exc | tmo;
    leds_d[LED_DATA_W-1:0]   = data;
  end

  always_ff @(posedge clk) begin
    if (reset) leds <= '0;
    else       leds <= leds_d;
  end

endmodule

// File: rtl/sys_run_ctrl.sv
// Run controller between board inputs and the MIPS core: holds the core in
// reset, loads the start PC, runs it and stops it on halt, exception or timeout.
module sys_run_ctrl
  import sys_pkg::*;
#(
  parameter int unsigned      PC_W    = 8,
  parameter int unsigned      LED_W   = 27,
  parameter int unsigned      CYC_W   = 16,
  parameter logic [CYC_W-1:0] MAX_CYC = 16'hFFFF
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             SYS_load,
  input  logic [PC_W-1:0]  SYS_pc_val,
  input  logic [7:0]       SYS_output_sel,
  input  logic             cpu_halt,
  input  logic             cpu_exc,
  input  logic [31:0]      dbg_pc,
  input  logic [31:0]      dbg_instr,
  input  logic [31:0]      dbg_reg_data,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic             pc_load,
  output logic [31:0]      pc_load_val,
  output logic [4:0]       dbg_reg_addr,
  output logic [LED_W-1:0] SYS_leds
);

  logic [1:0]       state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             exc_q, exc_d;
  logic             tmo_q, tmo_d;
  logic             load_q;
  logic             load_rise;
  logic             unused_sel;

  assign load_rise    = SYS_load & ~load_q;
  assign pc_load_val  = 32'({SYS_pc_val, 2'b00});
  assign dbg_reg_addr = SYS_output_sel[4:0];
  assign unused_sel   = SYS_output_sel[5];

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
      tmo_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      tmo_q   <= tmo_d;
      load_q  <= SYS_load;
    end
  end

  // A new load edge in RUN wins over halt, exception and timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    tmo_d   = tmo_q;
    cpu_rst = 1'b1;
    cpu_ce  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_rise) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pc_load = 1'b1;
        cnt_d   = '0;
        exc_d   = 1'b0;
        tmo_d   = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        cpu_ce  = 1'b1;
        cnt_d   = cnt_q + CYC_W'(1);
        if (load_rise) begin
          state_d = ST_LOAD;
        end else if (cpu_exc) begin
          state_d = ST_HALT;
          exc_d   = 1'b1;
        end else if (cpu_halt) begin
          state_d = ST_HALT;
        end else if (cnt_q == MAX_CYC - CYC_W'(1)) begin
          state_d = ST_HALT;
          tmo_d   = 1'b1;
        end
      end
      ST_HALT: begin
        cpu_rst = 1'b0;
        if (load_rise) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sys_led_mux #(
    .LED_W(LED_W),
    .CYC_W(CYC_W)
  ) u_led_mux (
    .clk          (SYS_clk),
    .reset        (SYS_reset),
    .sel          (SYS_output_sel[7:6]),
    .state        (state_q),
    .exc          (exc_q),
    .tmo          (tmo_q),
    .cycle        (cnt_q),
    .dbg_pc       (dbg_pc),
    .dbg_instr    (dbg_instr),
    .dbg_reg_data (dbg_reg_data),
    .leds         (SYS_leds)
  );

endmodule

// File: tb/tb_sys_run_ctrl.sv
// Directed bench for sys_run_ctrl: table of LED-select vectors in IDLE plus
// hand-written load/run/halt/timeout/reset sequences (MAX_CYC reduced to 8).
module tb_sys_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, load, halt, exc;
  logic [7:0]  pc_val, sel;
  logic [31:0] d_pc, d_instr, d_reg;
  logic        cpu_rst, cpu_ce, pc_load;
  logic [31:0] pc_load_val;
  logic [4:0]  reg_addr;
  logic [26:0] leds;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses;

  sys_run_ctrl #(
    .PC_W(8), .LED_W(27), .CYC_W(16), .MAX_CYC(16'd8)
  ) dut (
    .SYS_clk        (clk),
    .SYS_reset      (reset),
    .SYS_load       (load),
    .SYS_pc_val     (pc_val),
    .SYS_output_sel (sel),
    .cpu_halt       (halt),
    .cpu_exc        (exc),
    .dbg_pc         (d_pc),
    .dbg_instr      (d_instr),
    .dbg_reg_data   (d_reg),
    .cpu_rst        (cpu_rst),
    .cpu_ce         (cpu_ce),
    .pc_load        (pc_load),
    .pc_load_val    (pc_load_val),
    .dbg_reg_addr   (reg_addr),
    .SYS_leds       (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sel;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rdata;
    logic [4:0]  exp_addr;
    logic [26:0] exp_leds;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; halt = 1'b0; exc = 1'b0;
    pc_val = 8'h00; sel = 8'h00;
    d_pc = 32'h0; d_instr = 32'h0; d_reg = 32'h0;

    // IDLE-state select vectors: status bits all 0, cycle field 0
    vecs[0] = '{8'h00, 32'hFF123456, 32'h0,        32'h0,        5'h00, 27'h0123456};
    vecs[1] = '{8'h40, 32'h0,        32'h00ABCDEF, 32'h0,        5'h00, 27'h0ABCDEF};
    vecs[2] = '{8'h83, 32'h0,        32'h0,        32'hABCDEF12, 5'h03, 27'h0CDEF12};
    vecs[3] = '{8'hC0, 32'h12345678, 32'h9ABCDEF0, 32'h11111111, 5'h00, 27'h0000000};
    vecs[4] = '{8'h9F, 32'h0,        32'h0,        32'h12345678, 5'h1F, 27'h0345678};
    vecs[5] = '{8'h25, 32'hA5A5A5A5, 32'h0,        32'h0,        5'h05, 27'h0A5A5A5};

    tick(); tick();
    reset = 1'b0;

    // Idle after reset with no load
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rst", 32'(cpu_rst), 32'd1);
      chk("idle_ce", 32'(cpu_ce), 32'd0);
      chk("idle_pcl", 32'(pc_load), 32'd0);
      chk("idle_leds", 32'(leds), 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel; d_pc = vecs[i].pc; d_instr = vecs[i].instr; d_reg = vecs[i].rdata;
      #1;
      chk("vec_addr", 32'(reg_addr), 32'(vecs[i].exp_addr));
      tick();
      chk("vec_leds", 32'(leds), 32'(vecs[i].exp_leds));
      chk("vec_rst", 32'(cpu_rst), 32'd1);
    end
    sel = 8'h00; d_pc = 32'h0; d_instr = 32'h0; d_reg = 32'h0;
    tick();

    // Held load: one LOAD pulse, RUN, then timeout after 8 RUN cycles
    pc_val = 8'h10; load = 1'b1;
    tick();
    chk("load_pcl", 32'(pc_load), 32'd1);
    chk("load_val", pc_load_val, 32'h40);
    chk("load_rst", 32'(cpu_rst), 32'd1);
    chk("load_ce", 32'(cpu_ce), 32'd0);
    pulses = 1;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (pc_load) pulses++;
      if (i == 1) begin
        chk("run_rst", 32'(cpu_rst), 32'd0);
        chk("run_ce", 32'(cpu_ce), 32'd1);
      end
      if (i == 8) chk("run_last_ce", 32'(cpu_ce), 32'd1);
      if (i == 9) chk("tmo_ce", 32'(cpu_ce), 32'd0);
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("halt_rst", 32'(cpu_rst), 32'd0);
    sel = 8'hC0;
    tick();
    chk("tmo_leds", 32'(leds), 32'h3B00008);

    // Halt after 5 RUN cycles
    load = 1'b0; tick();
    pc_val = 8'hFF; load = 1'b1;
    tick();
    chk("load2_pcl", 32'(pc_load), 32'd1);
    chk("load2_val", pc_load_val, 32'h3FC);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_halt_ce", 32'(cpu_ce), 32'd1);
    halt = 1'b1;
    tick();
    chk("halt_ce", 32'(cpu_ce), 32'd0);
    chk("halt_rst2", 32'(cpu_rst), 32'd0);
    tick();
    chk("halt_leds", 32'(leds), 32'h2300005);

    // Load edge and exception together in RUN: reload wins, exc stays clear
    halt = 1'b0; load = 1'b0; tick();
    load = 1'b1; tick();
    load = 1'b0; tick();
    tick();
    load = 1'b1; exc = 1'b1;
    tick();
    chk("prio_pcl", 32'(pc_load), 32'd1);
    exc = 1'b0;
    tick();
    chk("prio_ce", 32'(cpu_ce), 32'd1);
    tick();
    chk("prio_run_led", 32'(leds[26]), 32'd1);
    chk("prio_flag_led", 32'(leds[24]), 32'd0);
    exc = 1'b1;
    tick();
    chk("exc_ce", 32'(cpu_ce), 32'd0);
    exc = 1'b0;
    tick();
    chk("exc_flag_led", 32'(leds[24]), 32'd1);
    chk("exc_halt_led", 32'(leds[25]), 32'd1);
    chk("exc_stat", 32'(leds[23:22]), 32'd1);

    // Synchronous reset mid-RUN
    load = 1'b0; tick();
    load = 1'b1; tick();
    tick(); tick();
    chk("mid_run_ce", 32'(cpu_ce), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_rst", 32'(cpu_rst), 32'd1);
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_pcl", 32'(pc_load), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    reset = 1'b0; load = 1'b0;
    tick();
    chk("post_rst_leds", 32'(leds), 32'd0);

    // Reset mid-LOAD; load_q clears so a still-high load retriggers afterwards
    load = 1'b1; tick();
    chk("ml_pcl", 32'(pc_load), 32'd1);
    reset = 1'b1; tick();
    chk("ml_rst_pcl", 32'(pc_load), 32'd0);
    chk("ml_rst_rst", 32'(cpu_rst), 32'd1);
    reset = 1'b0; tick();
    chk("ml_relaunch", 32'(pc_load), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
